fir_mac_stream: RTL and testbench

- Parametrised, time-multiplexed successor of the team's fixed 32-tap FIR.
- Runs NTAPS taps through one signed multiply-accumulate datapath, one tap per cycle, and keeps coefficients in a runtime-writable register file.
- Uses valid/ready handshakes on input and output, and saturates and rounds the result.
- A flush command drains the delay line with zero samples; used ahead of the FFT/frequency-analysis stage.

---
 rtl/fir_mac_stream.sv | 147 ++++++++++++++
 tb/tb_fir_mac_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_stream.sv
// Time-multiplexed FIR: one signed MAC per cycle over NTAPS taps, runtime coefficient
// register file, valid/ready on both sides, round-half-up and saturation on the result.
module fir_mac_stream #(
    parameter int NTAPS     = 32,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        data,
    input  logic                     flush,
    input  logic                     frame_clr,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     fir_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        fir_d,
    output logic                     fir_last
);

    localparam int AW     = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;
    localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_q;
    logic signed [DATA_W-1:0]  x_q [NTAPS];
    logic signed [COEF_W-1:0]  c_q [NTAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic [AW-1:0]             k_q;
    logic [AW-1:0]             flush_cnt_q;
    logic                      last_q;
    logic                      fir_valid_q;
    logic                      fir_last_q;
    logic [DATA_W-1:0]         fir_d_q;

    logic signed [PROD_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   rnd_d;
    logic signed [ACC_W-1:0]   shifted_d;
    logic [DATA_W-1:0]         fir_d_d;

    assign in_ready  = (state_q == IDLE) && !flush && (flush_cnt_q == '0);
    assign fir_valid = fir_valid_q;
    assign fir_last  = fir_last_q;
    assign fir_d     = fir_d_q;

    // Only the final tap's sum (acc_d on k == NTAPS-1) is rounded and saturated.
    always_comb begin
        prod_d    = c_q[k_q] * x_q[k_q];
        acc_d     = acc_q + {{AW{prod_d[PROD_W-1]}}, prod_d};
        rnd_d     = acc_d + RND_C;
        shifted_d = rnd_d >>> COEF_FRAC;
        fir_d_d   = shifted_d[DATA_W-1:0];
        if (shifted_d > SAT_MAX) begin
            fir_d_d = SAT_MAX[DATA_W-1:0];
        end else if (shifted_d < SAT_MIN) begin
            fir_d_d = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            flush_cnt_q <= '0;
            last_q      <= 1'b0;
            fir_valid_q <= 1'b0;
            fir_last_q  <= 1'b0;
            fir_d_q     <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (frame_clr) begin
            // Coefficients and fir_d deliberately survive a frame clear.
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            flush_cnt_q <= '0;
            last_q      <= 1'b0;
            fir_valid_q <= 1'b0;
            fir_last_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < NTAPS)) begin
                        c_q[coef_addr] <= coef_wdata;
                    end
                    if (flush && (flush_cnt_q == '0)) begin
                        flush_cnt_q <= AW'(NTAPS - 1);
                    end else if (flush_cnt_q != '0) begin
                        x_q[0] <= '0;
                        for (int i = 1; i < NTAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                        last_q      <= (flush_cnt_q == AW'(1));
                        acc_q       <= '0;
                        k_q         <= '0;
                        state_q     <= MAC;
                    end else if (in_valid) begin
                        x_q[0] <= data;
                        for (int i = 1; i < NTAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        last_q  <= 1'b0;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    if (k_q == AW'(NTAPS - 1)) begin
                        fir_d_q     <= fir_d_d;
                        fir_valid_q <= 1'b1;
                        fir_last_q  <= last_q;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        fir_valid_q <= 1'b0;
                        fir_last_q  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_stream.sv
// Directed bench for fir_mac_stream (NTAPS=4): a behavioural model pushes expected
// outputs into a scoreboard queue on each accepted sample; outputs pop and compare.
module tb_fir_mac_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data;
    logic        flush;
    logic        frame_clr;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [19:0] coef_wdata;
    logic        fir_valid;
    logic        out_ready;
    logic [15:0] fir_d;
    logic        fir_last;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] d;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    longint      mx[4];
    longint      mc[4];
    logic [15:0] last_out;

    fir_mac_stream #(
        .NTAPS(4), .DATA_W(16), .COEF_W(20), .COEF_FRAC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .flush      (flush),
        .frame_clr  (frame_clr),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .fir_valid  (fir_valid),
        .out_ready  (out_ready),
        .fir_d      (fir_d),
        .fir_last   (fir_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < 4; k++) s += mc[k] * mx[k];
        s = (s + 64'sd32768) >>> 16;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic void model_shift(input logic [15:0] d);
        logic signed [15:0] sd;
        sd = d;
        for (int i = 3; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = longint'(sd);
    endfunction

    function automatic void model_clear_x();
        for (int i = 0; i < 4; i++) mx[i] = 0;
    endfunction

    task automatic wcoef(input logic [1:0] a, input logic [19:0] v);
        logic signed [19:0] sv;
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_wdata = v;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        sv = v;
        mc[a] = longint'(sv);
    endtask

    task automatic do_frame_clr();
        @(negedge clk);
        frame_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_clr = 1'b0;
        model_clear_x();
    endtask

    // Returns at the negedge following the accept edge.
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        data     = d;
        @(posedge clk);
        model_shift(d);
        sb.push_back('{model_out(), 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_after_accept", in_ready, 0);
    endtask

    // Waits for fir_valid, compares against the scoreboard, handshakes if out_ready.
    task automatic recv(input bit chk_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!fir_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("fir_valid_seen", fir_valid, 1);
        if (chk_lat) check("latency", lat, 4);
        check("in_ready_busy", in_ready, 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("fir_d", fir_d, e.d);
            check("fir_last", fir_last, e.last);
        end else begin
            check("sb_underflow", sb.size(), 1);
        end
        last_out = fir_d;
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_recv(input logic [15:0] d);
        send(d);
        recv(1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; data = '0; flush = 1'b0; frame_clr = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin mx[i] = 0; mc[i] = 0; end
        last_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_fir_valid", fir_valid, 0);
        check("rst_fir_d", fir_d, 0);
        check("rst_fir_last", fir_last, 0);
        check("rst_in_ready", in_ready, 1);

        // Identity tap and latency
        wcoef(2'd0, 20'h10000);
        send_recv(16'h0100);
        check("in_ready_after_handshake", in_ready, 1);

        // Pure delay on tap 3
        do_frame_clr();
        wcoef(2'd0, 20'h00000);
        wcoef(2'd3, 20'h10000);
        send_recv(16'h0100);
        send_recv(16'h0200);
        send_recv(16'h0300);
        send_recv(16'h0400);

        // Saturation both ways
        do_frame_clr();
        for (int i = 0; i < 4; i++) wcoef(2'(i), 20'h10000);
        repeat (4) send_recv(16'h7F00);
        repeat (4) send_recv(16'h8100);

        // Rounding
        do_frame_clr();
        wcoef(2'd0, 20'h08000);
        for (int i = 1; i < 4; i++) wcoef(2'(i), 20'h00000);
        send_recv(16'h0001);
        send_recv(16'hFFFF);
        send_recv(16'h0003);
        wcoef(2'd0, 20'hF8000);
        send_recv(16'h0001);

        // Backpressure
        wcoef(2'd0, 20'h10000);
        wcoef(2'd2, 20'h08000);
        out_ready = 1'b0;
        send(16'h1234);
        recv(1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_fir_valid", fir_valid, 1);
            check("bp_fir_d", fir_d, last_out);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_released_valid", fir_valid, 0);
        check("bp_released_ready", in_ready, 1);

        // Flush drains NTAPS-1 zeros, fir_last on the final one only
        do_frame_clr();
        wcoef(2'd0, 20'h10000);
        wcoef(2'd1, 20'h08000);
        wcoef(2'd2, 20'h00000);
        wcoef(2'd3, 20'h10000);
        send_recv(16'h0100);
        send_recv(16'h0200);
        send_recv(16'h0300);
        send_recv(16'h0400);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; data = 16'h1234;
        #1;
        check("flush_blocks_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_shift(16'h0000);
            sb.push_back('{model_out(), (i == 2)});
        end
        for (int i = 0; i < 3; i++) recv(1'b0);
        check("flush_done_ready", in_ready, 1);
        repeat (8) @(negedge clk);
        check("flush_no_extra_valid", fir_valid, 0);
        check("flush_idle_ready", in_ready, 1);

        // frame_clr in MAC aborts and zeroes history
        for (int i = 0; i < 4; i++) wcoef(2'(i), 20'h10000);
        send_recv(16'h0011);
        send_recv(16'h0022);
        send(16'h0033);
        @(negedge clk);
        frame_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_clr = 1'b0;
        void'(sb.pop_back());
        model_clear_x();
        for (int i = 0; i < 8; i++) begin
            check("abort_no_valid", fir_valid, 0);
            @(negedge clk);
        end
        check("abort_fir_d_hold", fir_d, last_out);
        send_recv(16'h0050);

        // Coefficient write during MAC is ignored
        do_frame_clr();
        wcoef(2'd0, 20'h10000);
        for (int i = 1; i < 4; i++) wcoef(2'(i), 20'h00000);
        send(16'h0020);
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 20'h20000;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        recv(1'b0);
        send_recv(16'h0030);

        // rst in OUT returns everything to reset values, coefficients included
        out_ready = 1'b0;
        send(16'h0040);
        recv(1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin mx[i] = 0; mc[i] = 0; end
        check("midrst_fir_valid", fir_valid, 0);
        check("midrst_fir_d", fir_d, 0);
        check("midrst_fir_last", fir_last, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        send_recv(16'h0100);

        check("sb_empty_at_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
